fsm_sec_param: RTL and testbench

FSM_SEC_PARAM -- requirements
Module: fsm_sec_param

---
 rtl/fsm_sec_param_if.sv | 24 ++
 rtl/fsm_sec_param.sv | 139 +++++++++++++
 tb/tb_fsm_sec_param.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fsm_sec_param_if.sv
// Handshake bundle between the sequencer and the device: listo/sw in,
// position, per-phase enables, error flag and state code out.
interface fsm_sec_param_if #(
  parameter int POS_W = 2
) ();
  logic             listo;
  logic             sw;
  logic [POS_W-1:0] posicion;
  logic             enable_inicio;
  logic             enable_leer;
  logic             enable_escribir;
  logic             error;
  logic [2:0]       estado;

  modport master (
    output listo, sw,
    input  posicion, enable_inicio, enable_leer, enable_escribir, error, estado
  );

  modport slave (
    input  listo, sw,
    output posicion, enable_inicio, enable_leer, enable_escribir, error, estado
  );
endinterface

// File: rtl/fsm_sec_param.sv
// Init / load / read / write / store sequencer walking register positions,
// with a per-state listo watchdog that latches into a sticky ERROR state.
module fsm_sec_param #(
  parameter int INIT_STEPS = 4,
  parameter int N_POS      = 4,
  parameter int TIMEOUT    = 255,
  parameter int POS_W      = 2
) (
  input  logic          clk,
  input  logic          reset,
  fsm_sec_param_if.slave bus
);

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    CARGAR   = 3'd1,
    LEER     = 3'd2,
    ESCRIBIR = 3'd3,
    GUARDAR  = 3'd4,
    ERROR    = 3'd5
  } state_e;

  localparam logic [POS_W-1:0] INIT_LAST   = POS_W'(INIT_STEPS - 1);
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(N_POS - 1);
  localparam logic [15:0]      TIMEOUT_CNT = 16'(TIMEOUT);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [15:0]      wait_q, wait_d;
  logic             en_ini_q, en_ini_d;
  logic             en_leer_q, en_leer_d;
  logic             en_esc_q, en_esc_d;
  logic             error_q, error_d;
  logic             timed_out;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    timed_out = (wait_q == TIMEOUT_CNT) && !bus.listo;

    case (state_q)
      INICIO: begin
        if (bus.listo) begin
          if (pos_q == INIT_LAST) begin
            state_d = CARGAR;
            pos_d   = '0;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end
      CARGAR: begin
        if (bus.listo) begin
          state_d = LEER;
          pos_d   = '0;
        end
      end
      LEER: begin
        if (bus.listo) begin
          if (pos_q == POS_LAST) begin
            pos_d   = '0;
            state_d = bus.sw ? ESCRIBIR : CARGAR;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end
      ESCRIBIR: begin
        // Dropping sw abandons the write pass even if listo arrives together.
        if (!bus.sw) begin
          state_d = CARGAR;
          pos_d   = '0;
        end else if (bus.listo) begin
          state_d = GUARDAR;
        end
      end
      GUARDAR: begin
        if (bus.listo) begin
          state_d = ESCRIBIR;
          pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end
      end
      ERROR: begin
        pos_d = '0;
      end
      default: begin
        state_d = INICIO;
        pos_d   = '0;
      end
    endcase

    if (timed_out && (state_q inside {INICIO, CARGAR, LEER, ESCRIBIR, GUARDAR})) begin
      state_d = ERROR;
      pos_d   = '0;
    end

    if ((state_d != state_q) || bus.listo) begin
      wait_d = '0;
    end else if (state_q == ERROR) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + 16'd1;
    end

    // Outputs decode the next state so they line up with estado after the edge.
    en_ini_d  = (state_d == INICIO);
    en_leer_d = (state_d == CARGAR) || (state_d == LEER);
    en_esc_d  = (state_d == ESCRIBIR) || (state_d == GUARDAR);
    error_d   = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INICIO;
      pos_q     <= '0;
      wait_q    <= '0;
      en_ini_q  <= 1'b0;
      en_leer_q <= 1'b0;
      en_esc_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      wait_q    <= wait_d;
      en_ini_q  <= en_ini_d;
      en_leer_q <= en_leer_d;
      en_esc_q  <= en_esc_d;
      error_q   <= error_d;
    end
  end

  assign bus.estado          = state_q;
  assign bus.posicion        = pos_q;
  assign bus.enable_inicio   = en_ini_q;
  assign bus.enable_leer     = en_leer_q;
  assign bus.enable_escribir = en_esc_q;
  assign bus.error           = error_q;

endmodule

// File: tb/tb_fsm_sec_param.sv
// Directed bench for fsm_sec_param: default instance for the pass sequences,
// a TIMEOUT=10 instance for the watchdog; expectations queued per step.
module tb_fsm_sec_param;

  localparam logic [2:0] S_INI = 3'd0, S_CAR = 3'd1, S_LEE = 3'd2,
                         S_ESC = 3'd3, S_GUA = 3'd4, S_ERR = 3'd5;
  localparam logic [2:0] EN_0 = 3'b000, EN_I = 3'b100, EN_L = 3'b010, EN_E = 3'b001;
  localparam bit INST_A = 1'b0, INST_B = 1'b1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fsm_sec_param_if #(.POS_W(2)) if_a ();
  fsm_sec_param_if #(.POS_W(2)) if_b ();

  fsm_sec_param #(.INIT_STEPS(4), .N_POS(4), .TIMEOUT(255), .POS_W(2)) dut_a (
    .clk(clk), .reset(rst), .bus(if_a.slave)
  );

  fsm_sec_param #(.INIT_STEPS(4), .N_POS(4), .TIMEOUT(10), .POS_W(2)) dut_b (
    .clk(clk), .reset(rst), .bus(if_b.slave)
  );

  typedef struct {
    string      tag;
    bit         inst;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [8:0] ex(input logic [2:0] st, input logic [1:0] p,
                                    input logic [2:0] en, input logic er);
    return {st, p, en, er};
  endfunction

  function automatic logic [8:0] obs_a();
    return {if_a.estado, if_a.posicion, if_a.enable_inicio, if_a.enable_leer,
            if_a.enable_escribir, if_a.error};
  endfunction

  function automatic logic [8:0] obs_b();
    return {if_b.estado, if_b.posicion, if_b.enable_inicio, if_b.enable_leer,
            if_b.enable_escribir, if_b.error};
  endfunction

  task automatic check_out();
    exp_t       t;
    logic [8:0] obs;
    t   = sb.pop_front();
    obs = t.inst ? obs_b() : obs_a();
    checks++;
    assert (obs === t.exp)
      else begin
        failures++;
        $error("FAIL %s observed={st,pos,ini,leer,esc,err}=%b expected=%b",
               t.tag, obs, t.exp);
      end
  endtask

  task automatic step(input logic r, input logic l, input logic s, input bit inst,
                      input string tag, input logic [8:0] e);
    exp_t t;
    @(negedge clk);
    rst       = r;
    if_a.listo = l;
    if_a.sw    = s;
    if_b.listo = l;
    if_b.sw    = s;
    t.tag  = tag;
    t.inst = inst;
    t.exp  = e;
    sb.push_back(t);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst        = 1'b1;
    if_a.listo = 1'b0;
    if_a.sw    = 1'b0;
    if_b.listo = 1'b0;
    if_b.sw    = 1'b0;

    // Reset state and first cycle after release
    step(1, 0, 0, INST_A, "reset_a", ex(S_INI, 0, EN_0, 0));
    step(1, 0, 0, INST_B, "reset_b", ex(S_INI, 0, EN_0, 0));
    step(0, 0, 0, INST_A, "post_rst_idle", ex(S_INI, 0, EN_I, 0));

    // Init: four single-cycle listo pulses
    step(0, 1, 0, INST_A, "init_p1", ex(S_INI, 1, EN_I, 0));
    step(0, 0, 0, INST_A, "init_hold1", ex(S_INI, 1, EN_I, 0));
    step(0, 1, 0, INST_A, "init_p2", ex(S_INI, 2, EN_I, 0));
    step(0, 0, 0, INST_A, "init_hold2", ex(S_INI, 2, EN_I, 0));
    step(0, 1, 0, INST_A, "init_p3", ex(S_INI, 3, EN_I, 0));
    step(0, 0, 0, INST_A, "init_hold3", ex(S_INI, 3, EN_I, 0));
    step(0, 1, 0, INST_A, "init_done", ex(S_CAR, 0, EN_L, 0));
    step(0, 0, 0, INST_A, "cargar_hold", ex(S_CAR, 0, EN_L, 0));

    // Read-only pass returns to CARGAR
    step(0, 1, 0, INST_A, "ro_to_leer", ex(S_LEE, 0, EN_L, 0));
    step(0, 1, 0, INST_A, "ro_pos1", ex(S_LEE, 1, EN_L, 0));
    step(0, 1, 0, INST_A, "ro_pos2", ex(S_LEE, 2, EN_L, 0));
    step(0, 1, 0, INST_A, "ro_pos3", ex(S_LEE, 3, EN_L, 0));
    step(0, 1, 0, INST_A, "ro_back_cargar", ex(S_CAR, 0, EN_L, 0));

    // Read pass then write pass
    step(0, 1, 1, INST_A, "rw_to_leer", ex(S_LEE, 0, EN_L, 0));
    for (int i = 1; i < 4; i++)
      step(0, 1, 1, INST_A, "rw_leer_pos", ex(S_LEE, 2'(i), EN_L, 0));
    step(0, 1, 1, INST_A, "rw_to_escribir", ex(S_ESC, 0, EN_E, 0));
    step(0, 1, 1, INST_A, "wr_guardar0", ex(S_GUA, 0, EN_E, 0));
    step(0, 0, 1, INST_A, "wr_guardar_hold", ex(S_GUA, 0, EN_E, 0));
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 1, INST_A, "wr_escribir", ex(S_ESC, 2'(i), EN_E, 0));
      step(0, 1, 1, INST_A, "wr_guardar", ex(S_GUA, 2'(i), EN_E, 0));
    end
    step(0, 1, 1, INST_A, "wr_wrap", ex(S_ESC, 0, EN_E, 0));

    // sw drop beats listo in ESCRIBIR
    step(0, 1, 0, INST_A, "sw_drop_priority", ex(S_CAR, 0, EN_L, 0));

    // listo held high from reset release
    step(1, 0, 0, INST_A, "reset_again", ex(S_INI, 0, EN_0, 0));
    step(0, 1, 0, INST_A, "held_1", ex(S_INI, 1, EN_I, 0));
    step(0, 1, 0, INST_A, "held_2", ex(S_INI, 2, EN_I, 0));
    step(0, 1, 0, INST_A, "held_3", ex(S_INI, 3, EN_I, 0));
    step(0, 1, 0, INST_A, "held_4_cargar", ex(S_CAR, 0, EN_L, 0));
    step(0, 1, 0, INST_A, "held_5_leer", ex(S_LEE, 0, EN_L, 0));
    step(0, 1, 0, INST_A, "held_6_pos1", ex(S_LEE, 1, EN_L, 0));

    // Reset mid-pass
    step(1, 0, 0, INST_A, "reset_mid_pass", ex(S_INI, 0, EN_0, 0));

    // Watchdog on the TIMEOUT=10 instance
    step(0, 1, 0, INST_B, "b_init_p1", ex(S_INI, 1, EN_I, 0));
    step(0, 1, 0, INST_B, "b_init_p2", ex(S_INI, 2, EN_I, 0));
    step(0, 1, 0, INST_B, "b_init_p3", ex(S_INI, 3, EN_I, 0));
    step(0, 1, 0, INST_B, "b_cargar", ex(S_CAR, 0, EN_L, 0));
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, INST_B, "b_wait_cargar", ex(S_CAR, 0, EN_L, 0));
    step(0, 1, 0, INST_B, "b_listo_beats_timeout", ex(S_LEE, 0, EN_L, 0));
    step(0, 1, 0, INST_B, "b_leer1", ex(S_LEE, 1, EN_L, 0));
    step(0, 1, 0, INST_B, "b_leer2", ex(S_LEE, 2, EN_L, 0));
    step(0, 1, 0, INST_B, "b_leer3", ex(S_LEE, 3, EN_L, 0));
    step(0, 1, 0, INST_B, "b_back_cargar", ex(S_CAR, 0, EN_L, 0));
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, INST_B, "b_wait_edge", ex(S_CAR, 0, EN_L, 0));
    step(0, 0, 0, INST_B, "b_timeout", ex(S_ERR, 0, EN_0, 1));
    step(0, 1, 1, INST_B, "b_err_ignores_listo", ex(S_ERR, 0, EN_0, 1));
    step(0, 0, 0, INST_B, "b_err_sticky", ex(S_ERR, 0, EN_0, 1));
    step(1, 0, 0, INST_B, "b_reset_clears", ex(S_INI, 0, EN_0, 0));
    step(0, 0, 0, INST_B, "b_post_reset", ex(S_INI, 0, EN_I, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
